in_debounce: RTL and testbench
==============================

IN_DEBOUNCE -- requirements
Module: in_debounce

Interface
REQ-001 The block SHALL sit directly upstream of the 2-state Moore FSM and SHALL drive that FSM's in input from its clean output.
REQ-002 Parameter SYNC_STAGES SHALL default to 2 and SHALL set the synchronizer depth (legal range 2..4).
REQ-003 Parameter DEBOUNCE_CYCLES SHALL default to 4 and SHALL set the consecutive stable synchronized samples required to accept a level change (legal range 2..255).
REQ-004 Port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all logic updates on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit wide, synchronous and active-high.
REQ-006 Port raw_in SHALL be an input, 1 bit wide, carrying the asynchronous, possibly bouncing level.
REQ-007 Port clean SHALL be an output, 1 bit wide, carrying the debounced registered level.
REQ-008 Port rise SHALL be an output, 1 bit wide, pulsing high for 1 cycle in the cycle where clean becomes 1.
REQ-009 Port fall SHALL be an output, 1 bit wide, pulsing high for 1 cycle in the cycle where clean becomes 0.

Function
REQ-010 raw_in SHALL pass through a SYNC_STAGES-deep flop chain; the last flop output is s, and only s feeds the FSM.
REQ-011 The FSM SHALL have 4 states: LOW, WAIT_HIGH, HIGH and WAIT_LOW, and SHALL use an 8-bit counter cnt.
REQ-012 In LOW, s=1 SHALL move the FSM to WAIT_HIGH with cnt=1; otherwise the FSM SHALL hold with cnt=0.
REQ-013 In WAIT_HIGH, s=0 SHALL move the FSM to LOW with cnt=0 (an aborted transition).
REQ-014 In WAIT_HIGH, s=1 with cnt=DEBOUNCE_CYCLES-1 SHALL move the FSM to HIGH, set clean=1 and rise=1, and clear cnt.
REQ-015 In WAIT_HIGH, s=1 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt.
REQ-016 HIGH and WAIT_LOW SHALL mirror REQ-012..015 with polarity inverted, producing clean=0 and fall=1.
REQ-017 clean SHALL change only on completion of WAIT_HIGH or WAIT_LOW; no combinational path SHALL exist from raw_in to any output.
REQ-018 Latency from raw_in settling before edge E1 to clean updating SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES edges (6 with defaults).
REQ-019 rise and fall SHALL never be high in the same cycle, and each SHALL be low in every cycle other than its transition cycle.
REQ-020 A pulse on raw_in that yields fewer than DEBOUNCE_CYCLES consecutive equal s samples SHALL leave clean, rise and fall unchanged.
REQ-021 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-022 While reset=1 at a rising edge, all synchronizer flops SHALL clear to 0, the state SHALL be LOW, and cnt SHALL be 0.
REQ-023 While reset=1 at a rising edge, clean, rise and fall SHALL be 0.
REQ-024 Reset asserted mid-WAIT SHALL abort the transition without producing a rise or fall pulse.
REQ-025 After reset release with raw_in=1, the first rise SHALL occur SYNC_STAGES+DEBOUNCE_CYCLES edges after the first non-reset edge.
REQ-026 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-027 With macro IN_DEBOUNCE_GLITCH_CNT_EN defined, the block SHALL add output glitch_cnt (8 bits), which increments on each aborted transition (WAIT_x to its originating state) and saturates at 255.
REQ-028 With IN_DEBOUNCE_GLITCH_CNT_EN defined, glitch_cnt SHALL clear to 0 on reset.
REQ-029 With IN_DEBOUNCE_GLITCH_CNT_EN undefined, the glitch_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Defaults; reset for 2 cycles; raw_in=1 held -> clean=1 and rise=1 for exactly 1 cycle, 6 edges after the first post-reset edge; fall stays 0.
REQ-031 clean=1; raw_in=0 held -> fall=1 for 1 cycle and clean=0 after 6 edges.
REQ-032 clean=0; raw_in high for 3 cycles then low -> clean, rise and fall stay 0; glitch_cnt=1 when the macro is enabled.
REQ-033 raw_in toggling every cycle for 50 cycles -> clean constant, and no rise or fall pulses.
REQ-034 raw_in=1 for 4 cycles, then reset pulsed for 1 cycle while in WAIT_HIGH -> no rise pulse, state LOW, clean=0; after release, re-qualification takes the full 6 edges.
REQ-035 300 aborted transitions with the macro enabled -> glitch_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/in_debounce.sv
// Input synchronizer plus debounce FSM feeding the downstream Moore FSM's input.
// Optional feature: define IN_DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module in_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  output logic       clean,
  output logic       rise,
  output logic       fall
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  logic [7:0]             r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0]             r_glitch_cnt;
`endif

  // Only the last synchronizer stage is allowed to reach the FSM.
  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LOW;
      r_cnt        <= '0;
      r_clean      <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
      r_glitch_cnt <= '0;
`endif
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        LOW: begin
          if (w_s) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= 8'd1;
          end else begin
            r_cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!w_s) begin
            r_state <= LOW;
            r_cnt   <= '0;
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
            if (r_glitch_cnt != '1) r_glitch_cnt <= r_glitch_cnt + 8'd1;
`endif
          end else if (r_cnt == CNT_LAST) begin
            r_state <= HIGH;
            r_cnt   <= '0;
            r_clean <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (!w_s) begin
            r_state <= WAIT_LOW;
            r_cnt   <= 8'd1;
          end else begin
            r_cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (w_s) begin
            r_state <= HIGH;
            r_cnt   <= '0;
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
            if (r_glitch_cnt != '1) r_glitch_cnt <= r_glitch_cnt + 8'd1;
`endif
          end else if (r_cnt == CNT_LAST) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign clean = r_clean;
  assign rise  = r_rise;
  assign fall  = r_fall;
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_in_debounce.sv
// Self-checking bench for in_debounce: directed vector table, corner sequences,
// and randomized stimulus against a run-length reference model.
module tb_in_debounce;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DC   = 4;

  logic       clk;
  logic       reset;
  logic       raw_in;
  logic       clean;
  logic       rise;
  logic       fall;
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  in_debounce #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .raw_in(raw_in),
    .clean (clean),
    .rise  (rise),
    .fall  (fall)
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic raw;
    logic c;
    logic r;
    logic f;
  } vec_t;

  vec_t vecs[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: raw samples travel through a delay queue; clean flips
  // once DC consecutive delayed samples disagree with it.
  logic m_q[$];
  logic m_clean, m_rise, m_fall;
  int   m_run;
  int   m_glitch;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int unsigned i = 0; i < SYNC; i++) m_q.push_back(1'b0);
    m_clean  = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_run    = 0;
    m_glitch = 0;
  endtask

  task automatic model_edge(input logic rst, input logic raw);
    logic s;
    if (rst) begin
      model_reset();
    end else begin
      s = m_q.pop_front();
      m_q.push_back(raw);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_clean) begin
        m_run++;
        if (m_run == int'(DC)) begin
          m_clean = s;
          m_rise  = s;
          m_fall  = !s;
          m_run   = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic raw);
    reset  = rst;
    raw_in = raw;
    @(posedge clk);
    model_edge(rst, raw);
    #1;
    chk("clean", int'(clean), int'(m_clean));
    chk("rise", int'(rise), int'(m_rise));
    chk("fall", int'(fall), int'(m_fall));
    chk("rise_fall_excl", int'(rise & fall), 0);
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt", int'(glitch_cnt), m_glitch);
`endif
  endtask

  task automatic add(input logic rst, input logic raw, input logic c, input logic r,
                     input logic f, input int n);
    vec_t v;
    v.rst = rst; v.raw = raw; v.c = c; v.r = r; v.f = f;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    int   hold;
    int   seen_edge;
    logic cur;
    logic clean0;

    reset  = 1'b1;
    raw_in = 1'b0;
    model_reset();

    // Rise after 6 edges, fall after 6 edges, then a 3-sample aborted pulse.
    add(1, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 5);
    add(0, 1, 1, 1, 0, 1);
    add(0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 5);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 8);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].raw);
      chk("tbl_clean", int'(clean), int'(vecs[i].c));
      chk("tbl_rise", int'(rise), int'(vecs[i].r));
      chk("tbl_fall", int'(fall), int'(vecs[i].f));
    end
`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_after_pulse", int'(glitch_cnt), 1);
`endif

    // Toggling every cycle never qualifies.
    step(1, 0);
    clean0 = clean;
    for (int i = 0; i < 50; i++) begin
      step(0, (i % 2) == 0);
      chk("toggle_clean", int'(clean), int'(clean0));
      chk("toggle_no_pulse", int'(rise | fall), 0);
    end

    // Reset in the middle of WAIT_HIGH, then full re-qualification.
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < 4; i++) step(0, 1);
    step(1, 1);
    chk("midwait_rst_clean", int'(clean), 0);
    chk("midwait_rst_rise", int'(rise), 0);
    seen_edge = 0;
    for (int i = 1; i <= 20 && seen_edge == 0; i++) begin
      step(0, 1);
      if (rise) seen_edge = i;
    end
    chk("requal_edges", seen_edge, int'(SYNC + DC));

`ifdef IN_DEBOUNCE_GLITCH_CNT_EN
    // Hundreds of aborted transitions must saturate the glitch counter.
    step(1, 0);
    for (int i = 0; i < 700; i++) step(0, (i % 2) == 0);
    chk("glitch_saturate", int'(glitch_cnt), 255);
`endif

    // Randomized runs with occasional reset.
    step(1, 0);
    cur  = 1'b0;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        cur  = $urandom_range(0, 1) != 0;
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      step($urandom_range(0, 199) == 0, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
